stepper_motion_controller: RTL



---
 rtl/stepper_pkg.sv | 30 +++
 rtl/step_pulse_timer.sv | 29 ++
 rtl/stepper_motion_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared types and helpers for the stepper motion controller: FSM states,
// microstep encodings and the quarter-step position weight of one step.
package stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_FIN
    } state_t;

    localparam logic [3:0] MS_FULL    = 4'd1;
    localparam logic [3:0] MS_HALF    = 4'd2;
    localparam logic [3:0] MS_QUARTER = 4'd4;

    function automatic logic ms_legal(input logic [3:0] ms);
        return (ms == MS_FULL) || (ms == MS_HALF) || (ms == MS_QUARTER);
    endfunction

    // Quarter-steps covered by one step pulse at the given resolution.
    function automatic logic [2:0] pos_step(input logic [3:0] ms);
        case (ms)
            MS_FULL: return 3'd4;
            MS_HALF: return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/step_pulse_timer.sv
// Loadable down-counter shared by the SETUP, HIGH and LOW waits; a load of N
// keeps the terminal-count flag low for N cycles, so the state lasts N+1.
module step_pulse_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/stepper_motion_controller.sv
// Move sequencer for one A3988 channel: accepts move commands, emits step
// pulses with guaranteed widths and dir setup, tracks position in quarter-steps.
module stepper_motion_controller
    import stepper_pkg::*;
#(
    parameter int STEP_HIGH_CYC = 20,
    parameter int DIR_SETUP_CYC = 4,
    parameter int CNT_W         = 16,
    parameter int POS_W         = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic                    cmd_dir,
    input  logic [3:0]              cmd_microstep,
    input  logic [CNT_W-1:0]        cmd_period,
    input  logic                    abort,
    input  logic                    morph_transition,
    output logic                    step,
    output logic                    dir,
    output logic [3:0]              microstep,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic                    cmd_err,
    output logic signed [POS_W-1:0] position
);

    localparam logic [CNT_W-1:0] HIGH_LOAD       = CNT_W'(STEP_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD_IDLE = CNT_W'(DIR_SETUP_CYC);
    localparam logic [CNT_W-1:0] SETUP_LOAD_STEP = CNT_W'(DIR_SETUP_CYC - 1);
    localparam logic [CNT_W:0]   MIN_PERIOD      = (CNT_W+1)'(2 * STEP_HIGH_CYC);
    localparam logic [CNT_W:0]   HIGH_CYC_W      = (CNT_W+1)'(STEP_HIGH_CYC);
    localparam logic [CNT_W:0]   MIN_LOW         = (CNT_W+1)'(3);

    state_t           state, next_state;
    logic             tmr_load, tmr_tc;
    logic [CNT_W-1:0] tmr_val;

    logic             dir_l;
    logic [3:0]       ms_l;
    logic [CNT_W-1:0] period_l;
    logic [CNT_W-1:0] remaining;
    logic             align_flag, aligned, abort_pend;
    logic [1:0]       align_cnt;
    logic [1:0]       morph_q;
    logic             morph_sync;

    logic             accept, cmd_legal;
    logic             go_setup, fin_abort, enter_fin;
    logic             setup_dir, need_align, align_fault, need_setup;
    logic [3:0]       setup_ms;
    logic [CNT_W:0]   period_eff, low_raw, low_cyc;
    logic [CNT_W-1:0] low_load;

    assign accept     = cmd_valid & cmd_ready;
    assign cmd_legal  = ms_legal(cmd_microstep);
    assign morph_sync = morph_q[1];

    // The first SETUP of a move decides from the live command, later ones
    // from the latched copy.
    assign setup_dir = (state == ST_IDLE) ? cmd_dir : dir_l;
    assign setup_ms  = (state == ST_IDLE) ? cmd_microstep : ms_l;

    // Moving into quarter mode is always safe; coarser modes need one
    // quarter-step alignment pulse per move unless the channel is at a boundary.
    assign need_align  = (setup_ms != microstep) && (setup_ms != MS_QUARTER) &&
                         !morph_sync && !(aligned && (state != ST_IDLE));
    assign align_fault = need_align && (align_cnt == 2'd3);
    assign need_setup  = (dir != dir_l) || (microstep != ms_l);

    assign period_eff = ({1'b0, period_l} > MIN_PERIOD) ? {1'b0, period_l} : MIN_PERIOD;
    assign low_raw    = period_eff - HIGH_CYC_W;
    assign low_cyc    = (low_raw < MIN_LOW) ? MIN_LOW : low_raw;
    assign low_load   = CNT_W'(low_cyc - (CNT_W+1)'(1));
    assign enter_fin  = (next_state == ST_FIN) && (state != ST_FIN);

    step_pulse_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        go_setup   = 1'b0;
        fin_abort  = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state)
            ST_IDLE: begin
                if (accept && cmd_legal) begin
                    if (cmd_steps == '0) next_state = ST_FIN;
                    else                 go_setup   = 1'b1;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    next_state = ST_FIN;
                    fin_abort  = 1'b1;
                end else if (tmr_tc) begin
                    next_state = ST_HIGH;
                    tmr_load   = 1'b1;
                    tmr_val    = HIGH_LOAD;
                end
            end
            ST_HIGH: begin
                // A pulse always runs its full width; abort is honoured after.
                if (tmr_tc) begin
                    if (abort || abort_pend) begin
                        next_state = ST_FIN;
                        fin_abort  = 1'b1;
                    end else begin
                        next_state = ST_LOW;
                        tmr_load   = 1'b1;
                        tmr_val    = low_load;
                    end
                end
            end
            ST_LOW: begin
                if (abort) begin
                    next_state = ST_FIN;
                    fin_abort  = 1'b1;
                end else if (tmr_tc) begin
                    if (align_flag)                     go_setup   = 1'b1;
                    else if (remaining == CNT_W'(1))    next_state = ST_FIN;
                    else if (need_setup)                go_setup   = 1'b1;
                    else begin
                        next_state = ST_HIGH;
                        tmr_load   = 1'b1;
                        tmr_val    = HIGH_LOAD;
                    end
                end
            end
            ST_FIN:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase

        if (go_setup) begin
            if (align_fault) begin
                next_state = ST_FIN;
                fin_abort  = 1'b1;
            end else begin
                next_state = ST_SETUP;
                tmr_load   = 1'b1;
                tmr_val    = (state == ST_IDLE) ? SETUP_LOAD_IDLE : SETUP_LOAD_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            morph_q <= 2'b00;
        end else begin
            morph_q <= {morph_q[0], morph_transition};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            step       <= 1'b0;
            dir        <= 1'b0;
            microstep  <= MS_FULL;
            done       <= 1'b0;
            aborted    <= 1'b0;
            cmd_err    <= 1'b0;
            position   <= '0;
            dir_l      <= 1'b0;
            ms_l       <= MS_FULL;
            period_l   <= '0;
            remaining  <= '0;
            align_flag <= 1'b0;
            aligned    <= 1'b0;
            abort_pend <= 1'b0;
            align_cnt  <= 2'd0;
        end else begin
            cmd_ready <= (next_state == ST_IDLE);
            busy      <= (next_state != ST_IDLE);
            step      <= (next_state == ST_HIGH);
            done      <= enter_fin;
            aborted   <= enter_fin && fin_abort;
            cmd_err   <= accept && !cmd_legal;

            if (accept && cmd_legal) begin
                dir_l      <= cmd_dir;
                ms_l       <= cmd_microstep;
                period_l   <= cmd_period;
                remaining  <= cmd_steps;
                aligned    <= 1'b0;
                align_flag <= 1'b0;
                abort_pend <= 1'b0;
            end

            if ((state == ST_HIGH) && abort) abort_pend <= 1'b1;

            if ((state == ST_LOW) && tmr_tc && !abort) begin
                if (align_flag) align_flag <= 1'b0;
                else            remaining  <= remaining - CNT_W'(1);
            end

            // Consecutive alignment attempts count until the channel reports a boundary.
            if (morph_sync) align_cnt <= 2'd0;

            if ((next_state == ST_SETUP) && (state != ST_SETUP)) begin
                dir <= setup_dir;
                if (need_align) begin
                    microstep  <= MS_QUARTER;
                    align_flag <= 1'b1;
                    aligned    <= 1'b1;
                    align_cnt  <= align_cnt + 2'd1;
                end else begin
                    microstep  <= setup_ms;
                end
            end

            if ((next_state == ST_HIGH) && (state != ST_HIGH)) begin
                if (dir) position <= position + POS_W'(pos_step(microstep));
                else     position <= position - POS_W'(pos_step(microstep));
            end
        end
    end

endmodule
